// File: rtl/snr_sweep_ctrl_pkg.sv
// Shared definitions for the SNR sweep controller: state encoding,
// flush length and default parameter values.
package snr_sweep_ctrl_pkg;

  localparam int unsigned DEF_SNR_WIDTH = 11;
  localparam int unsigned DEF_NPTS      = 8;
  localparam int unsigned DEF_CW        = 32;

  // Cycles of datapath reset applied after every sigma change.
  localparam int unsigned FLUSH_CYC     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    SETTLE,
    MEASURE,
    REPORT,
    FINISH
  } state_t;

endpackage

// File: rtl/snr_sweep_ctrl_sweep_table.sv
// Sweep table: DEPTH x W register file holding the sigma value of each point.
// Ports:
//   clk      system clock
//   i_we     write strobe (already qualified by the caller)
//   i_waddr  write index
//   i_wdata  value to store
//   i_raddr  read index
//   o_rdata  registered read data (a same-cycle write to i_raddr is forwarded)
// Contents are not reset so they survive a controller reset.
module sweep_table #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Write port plus registered read with write-through forwarding.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/snr_sweep_ctrl.sv
// SNR sweep controller: steps a noise level (sigma_scale) through a table,
// resets and settles the tx+channel datapath at each level, counts checker
// errors over a measurement window and reports one count per point.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             sweep begin / terminate requests
//   tbl_we/tbl_addr/tbl_data sweep-table write port (IDLE only)
//   n_points, settle_len,    sweep shape, sampled at start
//   meas_len
//   err_in                   error pulse from the downstream checker
//   sigma_scale, dp_rst      datapath controls
//   meas_en, busy            status
//   point_valid, point_idx,  per-point result
//   err_count
//   done                     end-of-sweep pulse
module snr_sweep_ctrl
  import snr_sweep_ctrl_pkg::*;
#(
  parameter  int unsigned SNR_WIDTH = DEF_SNR_WIDTH,
  parameter  int unsigned NPTS      = DEF_NPTS,
  parameter  int unsigned CW        = DEF_CW,
  localparam int unsigned PW        = $clog2(NPTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 tbl_we,
  input  logic [PW-1:0]        tbl_addr,
  input  logic [SNR_WIDTH-1:0] tbl_data,
  input  logic [PW:0]          n_points,
  input  logic [15:0]          settle_len,
  input  logic [CW-1:0]        meas_len,
  input  logic                 err_in,
  output logic [SNR_WIDTH-1:0] sigma_scale,
  output logic                 dp_rst,
  output logic                 meas_en,
  output logic                 busy,
  output logic                 point_valid,
  output logic [PW-1:0]        point_idx,
  output logic [CW-1:0]        err_count,
  output logic                 done
);

  state_t               r_state, w_state_nx;
  logic [PW-1:0]        r_idx, w_idx_nx;
  logic [PW:0]          r_npts;
  logic [15:0]          r_settle;
  logic [CW-1:0]        r_meas;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic [CW-1:0]        r_err, w_err_nx;
  logic                 w_dp_rst_nx;
  logic [SNR_WIDTH-1:0] r_sigma, w_tbl_rdata;
  logic                 r_dp_rst, r_meas_en, r_busy, r_point_valid, r_done;
  logic [PW-1:0]        r_point_idx;
  logic [CW-1:0]        r_err_count;
  logic [PW:0]          w_npts_clamp;
  logic                 w_start_go, w_abort_go, w_tbl_we;
  logic                 w_flush_end, w_settle_end, w_meas_end, w_last_pt;

  assign w_npts_clamp = (n_points > (PW+1)'(NPTS)) ? (PW+1)'(NPTS) : n_points;
  // Abort masks start in IDLE; abort itself only acts once a sweep is running.
  assign w_start_go   = (r_state == IDLE) && start && !abort;
  assign w_abort_go   = (r_state != IDLE) && abort;
  assign w_tbl_we     = (r_state == IDLE) && tbl_we;
  assign w_flush_end  = (r_cnt == CW'(FLUSH_CYC - 1));
  assign w_settle_end = (r_cnt == (CW'(r_settle) - CW'(1)));
  assign w_meas_end   = (r_cnt == (r_meas - CW'(1)));
  assign w_last_pt    = (((PW+1)'(r_idx) + (PW+1)'(1)) >= r_npts);

  // Read address follows the next index so table[idx] is ready during LOAD.
  sweep_table #(
    .W     (SNR_WIDTH),
    .DEPTH (NPTS),
    .AW    (PW)
  ) u_table (
    .clk     (clk),
    .i_we    (w_tbl_we),
    .i_waddr (tbl_addr),
    .i_wdata (tbl_data),
    .i_raddr (w_idx_nx),
    .o_rdata (w_tbl_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state, phase counter, error counter and point index.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_cnt_nx    = r_cnt + CW'(1);
    w_err_nx    = r_err;
    w_dp_rst_nx = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (w_start_go) begin
          w_idx_nx   = '0;
          w_state_nx = (w_npts_clamp == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        w_cnt_nx   = '0;
        w_err_nx   = '0;
        w_state_nx = FLUSH;
      end
      FLUSH: begin
        if (w_flush_end) begin
          w_cnt_nx = '0;
          if (r_settle != '0)    w_state_nx = SETTLE;
          else if (r_meas != '0) w_state_nx = MEASURE;
          else                   w_state_nx = REPORT;
        end
      end
      SETTLE: begin
        if (w_settle_end) begin
          w_cnt_nx   = '0;
          w_state_nx = (r_meas != '0) ? MEASURE : REPORT;
        end
      end
      MEASURE: begin
        // Saturating error count.
        if (err_in && (r_err != '1)) begin
          w_err_nx = r_err + CW'(1);
        end
        if (w_meas_end) begin
          w_cnt_nx   = '0;
          w_state_nx = REPORT;
        end
      end
      REPORT: begin
        w_cnt_nx = '0;
        if (!w_last_pt) begin
          w_idx_nx   = r_idx + PW'(1);
          w_state_nx = LOAD;
        end else begin
          w_state_nx = FINISH;
        end
      end
      FINISH: begin
        w_cnt_nx   = '0;
        w_state_nx = IDLE;
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = IDLE;
      end
    endcase
    // Abort drops the partial point and holds the datapath in reset.
    if (w_abort_go) begin
      w_state_nx  = FINISH;
      w_cnt_nx    = '0;
      w_dp_rst_nx = 1'b1;
    end
    if (w_state_nx == FLUSH) begin
      w_dp_rst_nx = 1'b1;
    end
  end

  // Counters, sampled sweep parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= '0;
      r_cnt         <= '0;
      r_err         <= '0;
      r_npts        <= '0;
      r_settle      <= '0;
      r_meas        <= '0;
      r_sigma       <= '0;
      r_dp_rst      <= 1'b1;
      r_meas_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_point_valid <= 1'b0;
      r_point_idx   <= '0;
      r_err_count   <= '0;
      r_done        <= 1'b0;
    end else begin
      r_idx         <= w_idx_nx;
      r_cnt         <= w_cnt_nx;
      r_err         <= w_err_nx;
      r_dp_rst      <= w_dp_rst_nx;
      r_meas_en     <= (w_state_nx == MEASURE);
      r_busy        <= (w_state_nx != IDLE);
      r_point_valid <= (w_state_nx == REPORT);
      r_done        <= (w_state_nx == FINISH);
      if (w_start_go) begin
        r_npts   <= w_npts_clamp;
        r_settle <= settle_len;
        r_meas   <= meas_len;
      end
      if (r_state == LOAD) begin
        r_sigma <= w_tbl_rdata;
      end
      // w_err_nx includes an error on the final MEASURE cycle.
      if (w_state_nx == REPORT) begin
        r_point_idx <= r_idx;
        r_err_count <= w_err_nx;
      end
    end
  end

  assign sigma_scale = r_sigma;
  assign dp_rst      = r_dp_rst;
  assign meas_en     = r_meas_en;
  assign busy        = r_busy;
  assign point_valid = r_point_valid;
  assign point_idx   = r_point_idx;
  assign err_count   = r_err_count;
  assign done        = r_done;

endmodule

// File: tb/tb_snr_sweep_ctrl.sv
// Self-checking bench for snr_sweep_ctrl. Expected point reports are queued
// when a sweep is launched and compared as point_valid pulses arrive.
module tb_snr_sweep_ctrl;

  localparam int unsigned SW  = 11;
  localparam int unsigned NP  = 8;
  localparam int unsigned PWB = 3;
  localparam int unsigned CWB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, abort, tbl_we, err_in;
  logic [PWB-1:0] tbl_addr;
  logic [SW-1:0]  tbl_data;
  logic [PWB:0]   n_points;
  logic [15:0]    settle_len;
  logic [CWB-1:0] meas_len;
  logic [SW-1:0]  sigma_scale;
  logic           dp_rst, meas_en, busy, point_valid, done;
  logic [PWB-1:0] point_idx;
  logic [CWB-1:0] err_count;

  typedef struct {
    int idx;
    int cnt;
    int sigma;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tbl_model[NP];

  // Per-sweep observations filled in by drain_sweep.
  int first_meas, meas_cyc, dprst_cyc, done_cyc, pv_cyc, pv_cnt;

  snr_sweep_ctrl #(.SNR_WIDTH(SW), .NPTS(NP), .CW(CWB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .n_points    (n_points),
    .settle_len  (settle_len),
    .meas_len    (meas_len),
    .err_in      (err_in),
    .sigma_scale (sigma_scale),
    .dp_rst      (dp_rst),
    .meas_en     (meas_en),
    .busy        (busy),
    .point_valid (point_valid),
    .point_idx   (point_idx),
    .err_count   (err_count),
    .done        (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int data);
    tbl_we   = 1'b1;
    tbl_addr = PWB'(addr);
    tbl_data = SW'(data);
    tick;
    tbl_we = 1'b0;
    tbl_model[addr] = data;
  endtask

  task automatic push_points(input int n, input int cnt);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx = i; e.cnt = cnt; e.sigma = tbl_model[i];
      exp_q.push_back(e);
    end
  endtask

  // Leaves the DUT idle for two cycles, then raises start for one cycle (cycle 0).
  task automatic start_sweep(input int n, input int s, input int m);
    tick;
    tick;
    n_points   = (PWB+1)'(n);
    settle_len = 16'(s);
    meas_len   = CWB'(m);
    start      = 1'b1;
  endtask

  // Runs cycles 1..max_cyc after start, driving err_in/abort/poke/rst on the
  // requested cycles and comparing each point_valid against the queue.
  task automatic drain_sweep(input int max_cyc, input int err_lo, input int err_hi,
                             input int abort_at, input int poke_at, input int rst_at);
    exp_t e;
    first_meas = -1; meas_cyc = 0; dprst_cyc = 0; done_cyc = -1; pv_cyc = -1; pv_cnt = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      tick;
      start  = 1'b0;
      tbl_we = 1'b0;
      abort  = 1'b0;
      err_in = (k >= err_lo) && (k <= err_hi);
      if ((rst_at >= 0) && (k == rst_at + 1)) break;
      if (meas_en) begin
        meas_cyc++;
        if (first_meas < 0) first_meas = k;
      end
      if (dp_rst) dprst_cyc++;
      if (point_valid) begin
        pv_cnt++;
        pv_cyc = k;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_point_valid: cycle %0d idx %0d count %0d, none expected",
                   k, point_idx, err_count);
        end else begin
          e = exp_q.pop_front();
          if ((int'(point_idx) !== e.idx) || (int'(err_count) !== e.cnt) ||
              (int'(sigma_scale) !== e.sigma)) begin
            n_fail++;
            $display("FAIL point_report: cycle %0d got idx %0d count %0d sigma %0d, want idx %0d count %0d sigma %0d",
                     k, point_idx, err_count, sigma_scale, e.idx, e.cnt, e.sigma);
          end
        end
      end
      if (done) begin
        done_cyc = k;
        break;
      end
      if (k == abort_at) abort = 1'b1;
      if (k == poke_at) begin
        start = 1'b1; tbl_we = 1'b1; tbl_addr = 1; tbl_data = 777;
        n_points = 1; settle_len = 0; meas_len = 1;
      end
      if (k == rst_at) rst = 1'b1;
    end
    err_in = 1'b0;
    if ((done_cyc < 0) && (rst_at < 0)) begin
      n_checks++; n_fail++;
      $display("FAIL sweep_timeout: no done within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_checks++; if (sigma_scale !== '0) begin n_fail++; $display("FAIL reset_sigma: got %0d want 0", sigma_scale); end
    n_checks++; if (dp_rst !== 1'b1) begin n_fail++; $display("FAIL reset_dp_rst: got %b want 1", dp_rst); end
    n_checks++; if ({meas_en, busy, point_valid, done} !== 4'b0)
      begin n_fail++; $display("FAIL reset_flags: got meas_en/busy/pv/done %b want 0000", {meas_en, busy, point_valid, done}); end
    n_checks++; if ((point_idx !== '0) || (err_count !== '0))
      begin n_fail++; $display("FAIL reset_report: got idx %0d count %0d want 0 0", point_idx, err_count); end
    rst = 1'b0;
    tick;
    n_checks++; if (dp_rst !== 1'b0) begin n_fail++; $display("FAIL idle_dp_rst: got %b want 0", dp_rst); end
  endtask

  task automatic test_basic;
    push_points(3, 0);
    start_sweep(3, 2, 10);
    drain_sweep(200, -1, -1, -1, -1, -1);
    n_checks++; if (first_meas != 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", first_meas); end
    n_checks++; if (meas_cyc != 30) begin n_fail++; $display("FAIL basic_meas_cycles: got %0d want 30", meas_cyc); end
    n_checks++; if (dprst_cyc != 12) begin n_fail++; $display("FAIL basic_dp_rst_cycles: got %0d want 12", dprst_cyc); end
    n_checks++; if (done_cyc != 55) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 55", done_cyc); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_finish: got %b want 1", busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing_points: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    tick;
    n_checks++; if ((busy !== 1'b0) || (done !== 1'b0))
      begin n_fail++; $display("FAIL basic_after_done: got busy %b done %b want 0 0", busy, done); end
    n_checks++; if ((point_idx !== 2) || (sigma_scale !== 300))
      begin n_fail++; $display("FAIL basic_hold: got idx %0d sigma %0d want 2 300", point_idx, sigma_scale); end
  endtask

  task automatic test_err_window;
    push_points(1, 5);
    start_sweep(1, 2, 5);
    drain_sweep(100, 7, 13, -1, -1, -1);
    n_checks++; if (pv_cyc != 13) begin n_fail++; $display("FAIL err_report_cycle: got %0d want 13", pv_cyc); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL err_missing_point: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    tick;
    n_checks++; if (err_count !== 5) begin n_fail++; $display("FAIL err_count_hold: got %0d want 5", err_count); end
  endtask

  task automatic test_abort;
    push_points(1, 0);
    start_sweep(4, 2, 10);
    drain_sweep(200, -1, -1, 28, -1, -1);
    n_checks++; if (done_cyc != 29) begin n_fail++; $display("FAIL abort_done_cycle: got %0d want 29", done_cyc); end
    n_checks++; if ((pv_cnt != 1) || (exp_q.size() != 0))
      begin n_fail++; $display("FAIL abort_points: got %0d reports, %0d left, want 1 0", pv_cnt, exp_q.size()); end
    n_checks++; if ((dp_rst !== 1'b1) || (busy !== 1'b1))
      begin n_fail++; $display("FAIL abort_finish: got dp_rst %b busy %b want 1 1", dp_rst, busy); end
    n_checks++; if ((meas_cyc != 13) || (dprst_cyc != 9))
      begin n_fail++; $display("FAIL abort_cycles: got meas %0d dp_rst %0d want 13 9", meas_cyc, dprst_cyc); end
    exp_q.delete();
    tick;
    n_checks++; if ((busy !== 1'b0) || (dp_rst !== 1'b0))
      begin n_fail++; $display("FAIL abort_idle: got busy %b dp_rst %b want 0 0", busy, dp_rst); end
  endtask

  task automatic test_zero_points;
    start_sweep(0, 2, 10);
    drain_sweep(20, -1, -1, -1, -1, -1);
    n_checks++; if (done_cyc != 1) begin n_fail++; $display("FAIL zero_pts_done: got %0d want 1", done_cyc); end
    n_checks++; if ((dprst_cyc != 0) || (pv_cnt != 0) || (first_meas != -1))
      begin n_fail++; $display("FAIL zero_pts_quiet: got dp_rst %0d pv %0d meas %0d want 0 0 -1", dprst_cyc, pv_cnt, first_meas); end
  endtask

  task automatic test_zero_lens;
    push_points(1, 0);
    start_sweep(1, 0, 0);
    drain_sweep(50, -1, -1, -1, -1, -1);
    n_checks++; if ((pv_cyc != 6) || (done_cyc != 7))
      begin n_fail++; $display("FAIL zero_len_timing: got pv %0d done %0d want 6 7", pv_cyc, done_cyc); end
    n_checks++; if ((meas_cyc != 0) || (dprst_cyc != 4) || (exp_q.size() != 0))
      begin n_fail++; $display("FAIL zero_len_shape: got meas %0d dp_rst %0d left %0d want 0 4 0", meas_cyc, dprst_cyc, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_busy_poke;
    push_points(3, 0);
    start_sweep(3, 2, 10);
    drain_sweep(200, -1, -1, -1, 10, -1);
    n_checks++; if ((done_cyc != 55) || (pv_cnt != 3) || (exp_q.size() != 0))
      begin n_fail++; $display("FAIL poke_sweep: got done %0d pv %0d left %0d want 55 3 0", done_cyc, pv_cnt, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    start_sweep(3, 2, 10);
    drain_sweep(200, -1, -1, -1, -1, 12);
    n_checks++; if ((pv_cnt != 0) || (done !== 1'b0) || (point_valid !== 1'b0))
      begin n_fail++; $display("FAIL rst_mid_pulses: got pv %0d done %b want 0 0", pv_cnt, done); end
    n_checks++; if ((busy !== 1'b0) || (meas_en !== 1'b0) || (dp_rst !== 1'b1) || (sigma_scale !== '0))
      begin n_fail++; $display("FAIL rst_mid_outputs: got busy %b meas %b dp_rst %b sigma %0d want 0 0 1 0", busy, meas_en, dp_rst, sigma_scale); end
    n_checks++; if ((point_idx !== '0) || (err_count !== '0))
      begin n_fail++; $display("FAIL rst_mid_report: got idx %0d count %0d want 0 0", point_idx, err_count); end
    rst = 1'b0;
    push_points(2, 0);
    start_sweep(2, 0, 1);
    drain_sweep(100, -1, -1, -1, -1, -1);
    n_checks++; if ((done_cyc != 15) || (exp_q.size() != 0))
      begin n_fail++; $display("FAIL rst_table_kept: got done %0d left %0d want 15 0", done_cyc, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_clamp;
    push_points(NP, 0);
    start_sweep(15, 0, 1);
    drain_sweep(300, -1, -1, -1, -1, -1);
    n_checks++; if ((pv_cnt != 8) || (done_cyc != 57) || (exp_q.size() != 0))
      begin n_fail++; $display("FAIL clamp_points: got pv %0d done %0d left %0d want 8 57 0", pv_cnt, done_cyc, exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tbl_we = 1'b0; err_in = 1'b0;
    tbl_addr = '0; tbl_data = '0; n_points = '0; settle_len = '0; meas_len = '0;
    test_reset;
    for (int i = 0; i < int'(NP); i++) write_entry(i, 100 * (i + 1));
    test_basic;
    test_err_window;
    test_abort;
    test_zero_points;
    test_zero_lens;
    test_busy_poke;
    test_reset_mid;
    test_clamp;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
